iobuf_half_duplex_ctrl: RTL and testbench
=========================================

IOBUF_HALF_DUPLEX_CTRL -- requirements
Module: iobuf_half_duplex_ctrl

Interface
REQ-001 SHALL have parameter W, default 8: width of the bidirectional pin bank.
REQ-002 SHALL have parameter HOLD, default 2, legal 1..15: number of cycles the bank is driven per write.
REQ-003 SHALL have parameter TURN, default 2, legal 1..15: number of high-Z turnaround cycles after each write.
REQ-004 SHALL have parameter SAMP, default 3, legal 3..15: number of cycles in READ before capture.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have ports wr_req (input, 1), wr_data (input, W) and wr_ack (output, 1): write requester.
REQ-008 SHALL have ports rd_req (input, 1), rd_data (output, W) and rd_valid (output, 1): read requester.
REQ-009 SHALL have ports io_i (output, W), io_t (output, 1) and io_o (input, W): connect to the I, T (shared) and O pins of W tristate I/O buffers.

Function
REQ-010 SHALL implement FSM states HIZ, DRIVE, GAP and READ; all outputs SHALL be registered.
REQ-011 In HIZ, SHALL hold io_t=1 and evaluate requests every cycle.
REQ-012 If exactly one of wr_req or rd_req is high in HIZ, SHALL grant it.
REQ-013 If both are high in HIZ, SHALL grant the requester not served last (round-robin on a 1-bit last-grant flag).
REQ-014 On a write grant, SHALL latch wr_data into io_i and go to DRIVE; io_t=0 for exactly HOLD consecutive cycles, starting the cycle after the grant.
REQ-015 SHALL hold io_i stable for the whole of DRIVE.
REQ-016 SHALL pulse wr_ack high for one cycle, coincident with the last DRIVE cycle.
REQ-017 After DRIVE, SHALL go to GAP with io_t=1 for exactly TURN cycles, then return to HIZ; requests SHALL be ignored in GAP.
REQ-018 SHALL keep io_i at the last written value after DRIVE; io_i is don't-care while io_t=1.
REQ-019 SHALL pass io_o through a 2-flop synchronizer continuously.
REQ-020 On a read grant, SHALL go to READ for SAMP cycles with io_t=1.
REQ-021 In the last READ cycle, SHALL load the synchronizer output into rd_data.
REQ-022 rd_valid SHALL pulse high for one cycle, the cycle after the last READ cycle; the FSM is in HIZ that cycle and MAY grant again.
REQ-023 rd_data SHALL hold its value until the next capture.
REQ-024 A write MAY follow a read immediately with no gap; a read SHALL never begin before a complete GAP.
REQ-025 Requesters SHALL hold req until ack/valid and SHALL drop it the cycle after; a req still high then SHALL be treated as a new request.
REQ-026 Counters SHALL be 4 bits, load N-1 on state entry and exit at 0; there SHALL be no wrap-around.
REQ-027 Only the granted transfer is active at any time; requests arriving mid-transfer SHALL wait for HIZ.

Reset
REQ-028 On reset_n=0 at a clock edge, from any state, SHALL force state=HIZ, io_t=1, io_i=0, wr_ack=0, rd_valid=0, rd_data=0, synchronizer flops=0, counters=0, and last-grant=read (so the first contended grant goes to write).
REQ-029 A reset asserted mid-DRIVE SHALL release the bus (io_t=1) at that edge, with no wr_ack issued.

Structure
REQ-030 A shared package SHALL hold the state enum (HIZ, DRIVE, GAP, READ), the 4-bit counter width constant and the parameter defaults.
REQ-031 The 2-flop synchronizer SHALL be a sub-module iobuf_sync2, parameterised by W, with the same clk and reset_n.
REQ-032 The RTL SHALL NOT instantiate the tristate buffers; the top level connects io_i, io_t and io_o to W buffer instances.

Verification
REQ-033 Write only, HOLD=2, TURN=2, wr_data=8'hA5 at cycle 0 -> io_t=0 in cycles 1-2 with io_i=8'hA5; wr_ack=1 in cycle 2; io_t=1 from cycle 3; next grant possible no earlier than cycle 5.
REQ-034 Read only, SAMP=3, io_o=8'h3C held -> rd_valid=1 with rd_data=8'h3C exactly 4 cycles after the grant cycle; io_t=1 throughout.
REQ-035 wr_req and rd_req both high from reset release -> write granted first, then read, then write alternating; no two consecutive grants to the same side while both remain high.
REQ-036 Write immediately followed by read request -> read grant occurs only after TURN high-Z cycles; bench monitor asserts io_t never 0 during READ or GAP.
REQ-037 reset_n low for one cycle during the second DRIVE cycle -> io_t=1 at that edge, wr_ack never pulses, all outputs at reset values, and a fresh request afterward completes normally.
REQ-038 Parameter sweep HOLD=1/TURN=1/SAMP=3 and HOLD=15/TURN=15/SAMP=15 -> cycle counts match REQ-014, REQ-017 and REQ-020 exactly.

Source files
------------

// File: rtl/iobuf_half_duplex_ctrl_pkg.sv
// Shared types and constants for the half-duplex I/O buffer controller.
package iobuf_half_duplex_ctrl_pkg;

    // Phase counters are 4 bits wide, so every phase length is limited to 1..15.
    localparam int CNT_W = 4;

    // Default parameter values for the controller.
    localparam int DEF_W    = 8;
    localparam int DEF_HOLD = 2;
    localparam int DEF_TURN = 2;
    localparam int DEF_SAMP = 3;

    // Bus phases.
    typedef enum logic [1:0] {
        HIZ   = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2,
        READ  = 2'd3
    } state_e;

    typedef logic [CNT_W-1:0] cnt_t;

    // A phase lasting n cycles loads n-1 on entry and leaves when the count is 0.
    function automatic cnt_t cnt_load(input int n);
        return cnt_t'(n - 1);
    endfunction

endpackage

// File: rtl/iobuf_half_duplex_ctrl_sync2.sv
// Two-flop synchronizer for the pad input bank.
module iobuf_sync2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two back-to-back flops; the first may go metastable, the second gives it a cycle to settle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/iobuf_half_duplex_ctrl.sv
// Half-duplex controller for a bank of W tristate pads shared by one writer and one reader.
// The pads themselves live one level up: io_i/io_t/io_o go to the I/T/O pins of the buffers.
module iobuf_half_duplex_ctrl
    import iobuf_half_duplex_ctrl_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int HOLD = DEF_HOLD,
    parameter int TURN = DEF_TURN,
    parameter int SAMP = DEF_SAMP
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_req,
    input  logic [W-1:0] wr_data,
    output logic         wr_ack,
    input  logic         rd_req,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    output logic [W-1:0] io_i,
    output logic         io_t,
    input  logic [W-1:0] io_o
);

    localparam cnt_t L_HOLD = cnt_load(HOLD);
    localparam cnt_t L_TURN = cnt_load(TURN);
    localparam cnt_t L_SAMP = cnt_load(SAMP);
    // When the drive phase is a single cycle, the ack goes up together with the grant.
    localparam logic L_ACK_ON_GRANT = (HOLD == 1);

    state_e       r_state;
    cnt_t         r_cnt;
    logic         r_io_t;
    logic [W-1:0] r_io_i;
    logic         r_wr_ack;
    logic         r_rd_valid;
    logic [W-1:0] r_rd_data;
    logic         r_last_rd;   // 1: the reader was served last

    state_e       w_state_nxt;
    cnt_t         w_cnt_nxt;
    logic         w_io_t_nxt;
    logic [W-1:0] w_io_i_nxt;
    logic         w_wr_ack_nxt;
    logic         w_rd_valid_nxt;
    logic [W-1:0] w_rd_data_nxt;
    logic         w_last_rd_nxt;
    logic [W-1:0] w_sync;
    logic         w_gnt_wr;
    logic         w_gnt_rd;

    iobuf_sync2 #(.W(W)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (io_o),
        .o_q     (w_sync)
    );

    // Round-robin arbitration: a lone request wins, a tie goes to the side not served last.
    assign w_gnt_wr = wr_req && (!rd_req || r_last_rd);
    assign w_gnt_rd = rd_req && (!wr_req || !r_last_rd);

    // Next-state and next-output decode; every output is computed here and registered below.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_io_t_nxt     = 1'b1;
        w_io_i_nxt     = r_io_i;
        w_wr_ack_nxt   = 1'b0;
        w_rd_valid_nxt = 1'b0;
        w_rd_data_nxt  = r_rd_data;
        w_last_rd_nxt  = r_last_rd;

        case (r_state)
            HIZ: begin
                if (w_gnt_wr) begin
                    w_state_nxt   = DRIVE;
                    w_cnt_nxt     = L_HOLD;
                    w_io_t_nxt    = 1'b0;
                    w_io_i_nxt    = wr_data;
                    w_wr_ack_nxt  = L_ACK_ON_GRANT;
                    w_last_rd_nxt = 1'b0;
                end else if (w_gnt_rd) begin
                    w_state_nxt   = READ;
                    w_cnt_nxt     = L_SAMP;
                    w_last_rd_nxt = 1'b1;
                end
            end
            DRIVE: begin
                if (r_cnt == '0) begin
                    // Bus released here; io_i keeps the last written value.
                    w_state_nxt = GAP;
                    w_cnt_nxt   = L_TURN;
                end else begin
                    w_cnt_nxt    = r_cnt - cnt_t'(1);
                    w_io_t_nxt   = 1'b0;
                    // Ack lines up with the final driven cycle.
                    w_wr_ack_nxt = (r_cnt == cnt_t'(1));
                end
            end
            GAP: begin
                // Turnaround: requests are ignored until we are back in HIZ.
                if (r_cnt == '0) begin
                    w_state_nxt = HIZ;
                end else begin
                    w_cnt_nxt = r_cnt - cnt_t'(1);
                end
            end
            READ: begin
                if (r_cnt == '0) begin
                    // Capture on the last read cycle; valid shows up in the following HIZ cycle.
                    w_state_nxt    = HIZ;
                    w_rd_data_nxt  = w_sync;
                    w_rd_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - cnt_t'(1);
                end
            end
            default: begin
                w_state_nxt = HIZ;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers; reset releases the bus immediately from any state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= HIZ;
            r_cnt      <= '0;
            r_io_t     <= 1'b1;
            r_io_i     <= '0;
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_last_rd  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_io_t     <= w_io_t_nxt;
            r_io_i     <= w_io_i_nxt;
            r_wr_ack   <= w_wr_ack_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_last_rd  <= w_last_rd_nxt;
        end
    end

    assign io_t     = r_io_t;
    assign io_i     = r_io_i;
    assign wr_ack   = r_wr_ack;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_iobuf_half_duplex_ctrl.sv
// Bench: three controller instances (2/2/3, 1/1/3, 15/15/15) driven side by side and
// compared cycle by cycle against a transaction-level schedule of expected bus activity.
module tb_iobuf_half_duplex_ctrl;

    localparam int NI   = 3;
    localparam int NCYC = 2600;
    localparam int MAXC = NCYC + 64;

    function automatic int hold_of(input int k); return (k == 0) ? 2 : (k == 1) ? 1 : 15; endfunction
    function automatic int turn_of(input int k); return (k == 0) ? 2 : (k == 1) ? 1 : 15; endfunction
    function automatic int samp_of(input int k); return (k == 0) ? 3 : (k == 1) ? 3 : 15; endfunction

    logic       clk = 1'b0;
    logic       reset_n  [NI];
    logic       wr_req   [NI];
    logic       rd_req   [NI];
    logic       wr_ack   [NI];
    logic       rd_valid [NI];
    logic       io_t     [NI];
    logic [7:0] wr_data  [NI];
    logic [7:0] rd_data  [NI];
    logic [7:0] io_i     [NI];
    logic [7:0] io_o     [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int H = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        localparam int T = (g == 0) ? 2 : (g == 1) ? 1 : 15;
        localparam int S = (g == 0) ? 3 : (g == 1) ? 3 : 15;
        iobuf_half_duplex_ctrl #(.W(8), .HOLD(H), .TURN(T), .SAMP(S)) u_dut (
            .clk      (clk),
            .reset_n  (reset_n[g]),
            .wr_req   (wr_req[g]),
            .wr_data  (wr_data[g]),
            .wr_ack   (wr_ack[g]),
            .rd_req   (rd_req[g]),
            .rd_data  (rd_data[g]),
            .rd_valid (rd_valid[g]),
            .io_i     (io_i[g]),
            .io_t     (io_t[g]),
            .io_o     (io_o[g])
        );
    end

    // Expected per-cycle events, filled in when a grant is predicted.
    bit         exp_t0  [NI][MAXC];   // bank driven this cycle
    bit         exp_ack [NI][MAXC];
    bit         exp_vld [NI][MAXC];
    bit         rst_at  [NI][MAXC];   // first cycle after a reset edge
    logic [7:0] exp_wd  [NI][MAXC];
    logic [7:0] io_hist [NI][MAXC];

    int         free_at [NI];         // first cycle the arbiter may grant again
    bit         last_rd [NI];
    bit         chk_en  [NI];
    logic [7:0] m_rd    [NI];
    logic [7:0] m_wd    [NI];

    int n_chk;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Compare everything the instance shows during cycle c.
    task automatic check_cycle(input int k, input int c);
        if (rst_at[k][c]) begin
            chk_en[k] = 1'b1;
            m_rd[k]   = 8'h00;
            m_wd[k]   = 8'h00;
        end
        if (!chk_en[k]) return;
        // Capture happens at the end of the last read cycle, through two flops of delay.
        if (exp_vld[k][c] && c >= 3) m_rd[k] = io_hist[k][c-3];
        if (exp_t0[k][c]) m_wd[k] = exp_wd[k][c];
        chk($sformatf("io_t[%0d]@%0d", k, c),     32'(io_t[k]),     32'(!exp_t0[k][c]));
        chk($sformatf("wr_ack[%0d]@%0d", k, c),   32'(wr_ack[k]),   32'(exp_ack[k][c]));
        chk($sformatf("rd_valid[%0d]@%0d", k, c), 32'(rd_valid[k]), 32'(exp_vld[k][c]));
        chk($sformatf("rd_data[%0d]@%0d", k, c),  32'(rd_data[k]),  32'(m_rd[k]));
        chk($sformatf("io_i[%0d]@%0d", k, c),     32'(io_i[k]),     32'(m_wd[k]));
    endtask

    // Fixed-value spot checks on instance 0 (HOLD=2, TURN=2, SAMP=3) at scripted points.
    task automatic directed_checks(input int c);
        case (c)
            802:  chk("both_first_is_write", 32'(io_t[0]), 32'd0);
            810:  chk("both_read_valid", 32'(rd_valid[0]), 32'd1);
            811:  chk("both_then_write", 32'(io_t[0]), 32'd0);
            1105: chk("pre_rst_drive", 32'(io_t[0]), 32'd0);
            1106: begin
                chk("rst_release_io_t", 32'(io_t[0]), 32'd1);
                chk("rst_no_ack", 32'(wr_ack[0]), 32'd0);
                chk("rst_io_i", 32'(io_i[0]), 32'd0);
            end
            1111: begin
                chk("wr_drive1_io_t", 32'(io_t[0]), 32'd0);
                chk("wr_drive1_io_i", 32'(io_i[0]), 32'hA5);
                chk("wr_drive1_ack", 32'(wr_ack[0]), 32'd0);
            end
            1112: begin
                chk("wr_drive2_io_t", 32'(io_t[0]), 32'd0);
                chk("wr_drive2_ack", 32'(wr_ack[0]), 32'd1);
            end
            1113: begin
                chk("wr_gap_io_t", 32'(io_t[0]), 32'd1);
                chk("wr_gap_ack", 32'(wr_ack[0]), 32'd0);
                chk("wr_gap_io_i", 32'(io_i[0]), 32'hA5);
            end
            default: ;
        endcase
    endtask

    // Requester behaviour for cycle c: reset pulses, tied-high requests, scripted writes, or random traffic.
    task automatic drive_inputs(input int k, input int c);
        io_o[k]       = 8'($urandom);
        io_hist[k][c] = io_o[k];
        wr_data[k]    = 8'($urandom);
        if (c < 3 || c == 800 || c == 1101) begin
            reset_n[k] = 1'b0;
            wr_req[k]  = 1'b0;
            rd_req[k]  = 1'b0;
        end else if (c > 800 && c < 1101) begin
            reset_n[k] = 1'b1;
            wr_req[k]  = 1'b1;
            rd_req[k]  = 1'b1;
        end else if (c > 1101 && c < 1150) begin
            reset_n[k] = (c != 1105);
            rd_req[k]  = 1'b0;
            if (c == 1104 || c == 1110) begin
                wr_req[k]  = 1'b1;
                wr_data[k] = 8'hA5;
            end else if (c == 1105) begin
                wr_req[k] = 1'b0;
            end else if (wr_req[k] && exp_ack[k][c-1]) begin
                wr_req[k] = 1'b0;
            end
        end else begin
            reset_n[k] = (c < 1150) || ($urandom_range(0, 149) != 0);
            if (!reset_n[k]) begin
                wr_req[k] = 1'b0;
                rd_req[k] = 1'b0;
            end else begin
                if (wr_req[k] && exp_ack[k][c-1]) wr_req[k] = 1'b0;
                else if (!wr_req[k] && $urandom_range(0, 3) == 0) wr_req[k] = 1'b1;
                if (rd_req[k] && exp_vld[k][c-1]) rd_req[k] = 1'b0;
                else if (!rd_req[k] && $urandom_range(0, 3) == 0) rd_req[k] = 1'b1;
            end
        end
    endtask

    // Reference: decide grants from this cycle's inputs and schedule the resulting bus events.
    task automatic model_step(input int k, input int c);
        int h;
        int t;
        int s;
        h = hold_of(k);
        t = turn_of(k);
        s = samp_of(k);
        if (!reset_n[k]) begin
            for (int i = c + 1; i < c + 40 && i < MAXC; i++) begin
                exp_t0[k][i]  = 1'b0;
                exp_ack[k][i] = 1'b0;
                exp_vld[k][i] = 1'b0;
            end
            rst_at[k][c+1] = 1'b1;
            free_at[k]     = c + 1;
            last_rd[k]     = 1'b1;
            return;
        end
        if (c < free_at[k]) return;
        if (wr_req[k] && (!rd_req[k] || last_rd[k])) begin
            for (int i = 1; i <= h; i++) begin
                exp_t0[k][c+i] = 1'b1;
                exp_wd[k][c+i] = wr_data[k];
            end
            exp_ack[k][c+h] = 1'b1;
            free_at[k]      = c + h + t + 1;
            last_rd[k]      = 1'b0;
        end else if (rd_req[k] && (!wr_req[k] || !last_rd[k])) begin
            exp_vld[k][c+s+1] = 1'b1;
            free_at[k]        = c + s + 1;
            last_rd[k]        = 1'b1;
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int k = 0; k < NI; k++) begin
            reset_n[k] = 1'b0;
            wr_req[k]  = 1'b0;
            rd_req[k]  = 1'b0;
            wr_data[k] = 8'h00;
            io_o[k]    = 8'h00;
            free_at[k] = 0;
            last_rd[k] = 1'b1;
            chk_en[k]  = 1'b0;
            m_rd[k]    = 8'h00;
            m_wd[k]    = 8'h00;
        end
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) check_cycle(k, c);
            directed_checks(c);
            for (int k = 0; k < NI; k++) begin
                drive_inputs(k, c);
                model_step(k, c);
            end
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
